peak_result_streamer: RTL and testbench

// - Downstream of the histogram builder FSM: takes the per-pixel peak bins it emits once per completed

---
 rtl/peak_result_streamer.sv | 213 +++++++++++++++++++++
 tb/tb_peak_result_streamer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_result_streamer.sv
// peak_result_streamer
// Streams the per-pixel peak bins of each completed histogram frame, one
// pixel per beat, over a valid/ready interface.
// Two frames are buffered: the active frame being streamed and one pending
// frame. A frame that arrives while both are occupied is dropped and flagged.
// The histogram builder is never stalled.
// Optional feature: define PEAK_STREAM_FRAME_TAG_EN to add the frameTag[7:0]
// output. Each captured frame is tagged with a wrapping 8-bit sequence number.
module peak_result_streamer #(
    parameter  int NP        = 10,
    parameter  int PIXEL_NUM = 3,
    localparam int IDX_W     = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    peakValid,
    input  logic [NP*PIXEL_NUM-1:0] peakIn,
    input  logic                    outReady,
    output logic                    outValid,
    output logic [NP-1:0]           outData,
    output logic [IDX_W-1:0]        outPixelIdx,
    output logic                    outLast,
    output logic                    overrunErr,
    input  logic                    clrErr,
    output logic [7:0]              dropCnt
`ifdef PEAK_STREAM_FRAME_TAG_EN
    ,
    output logic [7:0]              frameTag
`endif
);

    // With a single pixel per frame, the first beat is also the last beat.
    localparam logic FIRST_IS_LAST = (PIXEL_NUM == 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t                  r_state;
    logic [NP*PIXEL_NUM-1:0] r_active;
    logic [NP*PIXEL_NUM-1:0] r_pend;
    logic                    r_pend_full;
    logic                    r_out_valid;
    logic [NP-1:0]           r_out_data;
    logic [IDX_W-1:0]        r_out_idx;
    logic                    r_out_last;
    logic                    r_err;
    logic [7:0]              r_drop_cnt;

    logic                    w_accept;
    logic                    w_last_acc;
    logic                    w_drop;
    logic [IDX_W-1:0]        w_idx_next;
    logic [NP-1:0]           w_next_pix;
    logic [NP-1:0]           w_active_pix [PIXEL_NUM];

    // A beat leaves when valid meets ready. The frame completes when that beat is the last one.
    assign w_accept   = r_out_valid & outReady;
    assign w_last_acc = w_accept & r_out_last;
    assign w_idx_next = r_out_idx + IDX_W'(1);

    // A drop happens only when both buffers stay occupied through this edge.
    assign w_drop = peakValid & (r_state == S_SEND) & ~w_last_acc & r_pend_full;

    // Split the active frame into per-pixel words for beat selection.
    generate
        for (genvar gi = 0; gi < PIXEL_NUM; gi++) begin : g_pix
            assign w_active_pix[gi] = r_active[gi*NP +: NP];
        end
    endgenerate

    // Pick the pixel that follows the one currently presented.
    always_comb begin
        w_next_pix = '0;
        for (int p = 0; p < PIXEL_NUM; p++) begin
            if (w_idx_next == IDX_W'(p)) begin
                w_next_pix = w_active_pix[p];
            end
        end
    end

    // Stream FSM: frame capture, pending promotion and registered beat outputs.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state     <= S_IDLE;
            r_active    <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (peakValid) begin
                        r_active    <= peakIn;
                        r_out_valid <= 1'b1;
                        r_out_data  <= peakIn[NP-1:0];
                        r_out_idx   <= '0;
                        r_out_last  <= FIRST_IS_LAST;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_last_acc) begin
                        if (r_pend_full) begin
                            // Promote pending with no bubble. A same-edge frame refills pending.
                            r_active    <= r_pend;
                            r_out_data  <= r_pend[NP-1:0];
                            r_out_idx   <= '0;
                            r_out_last  <= FIRST_IS_LAST;
                            r_pend_full <= peakValid;
                            if (peakValid) begin
                                r_pend <= peakIn;
                            end
                        end else if (peakValid) begin
                            // The new frame goes straight into active, back to back.
                            r_active   <= peakIn;
                            r_out_data <= peakIn[NP-1:0];
                            r_out_idx  <= '0;
                            r_out_last <= FIRST_IS_LAST;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_idx   <= '0;
                            r_out_last  <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end else begin
                        if (w_accept) begin
                            r_out_idx  <= w_idx_next;
                            r_out_data <= w_next_pix;
                            r_out_last <= (w_idx_next == IDX_W'(PIXEL_NUM - 1));
                        end
                        if (peakValid && !r_pend_full) begin
                            r_pend      <= peakIn;
                            r_pend_full <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Overrun tracking: the flag is sticky and the drop count saturates. A drop beats a simultaneous clear.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_err <= 1'b1;
            if (clrErr) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (clrErr) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

`ifdef PEAK_STREAM_FRAME_TAG_EN
    logic [7:0] r_tag_ctr;
    logic [7:0] r_active_tag;
    logic [7:0] r_pend_tag;
    logic       w_cap_direct;
    logic       w_cap_pend;
    logic       w_promote;

    // Tags follow each frame through the buffers. Only captured frames consume a tag.
    assign w_cap_direct = peakValid & ((r_state == S_IDLE) | (w_last_acc & ~r_pend_full));
    assign w_promote    = w_last_acc & r_pend_full;
    assign w_cap_pend   = peakValid & (w_promote |
                          ((r_state == S_SEND) & ~w_last_acc & ~r_pend_full));

    // Frame tag bookkeeping for active and pending frames.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_tag_ctr    <= '0;
            r_active_tag <= '0;
            r_pend_tag   <= '0;
        end else begin
            if (w_cap_direct || w_cap_pend) begin
                r_tag_ctr <= r_tag_ctr + 8'd1;
            end
            if (w_cap_direct) begin
                r_active_tag <= r_tag_ctr;
            end else if (w_promote) begin
                r_active_tag <= r_pend_tag;
            end
            if (w_cap_pend) begin
                r_pend_tag <= r_tag_ctr;
            end
        end
    end

    assign frameTag = r_active_tag;
`endif

    assign outValid    = r_out_valid;
    assign outData     = r_out_data;
    assign outPixelIdx = r_out_idx;
    assign outLast     = r_out_last;
    assign overrunErr  = r_err;
    assign dropCnt     = r_drop_cnt;

endmodule

// File: tb/tb_peak_result_streamer.sv
// Testbench for peak_result_streamer.
// A frame-level reference model and a scoreboard queue are fed at stimulus
// time. A separate monitor pops the queue and checks every accepted beat.
// It also checks valid, overrun status and hold stability on every cycle.
module tb_peak_result_streamer;

    localparam int NP  = 10;
    localparam int PIX = 3;
    localparam int IW  = 2;

    logic              clk = 1'b0;
    logic              res;
    logic              peakValid;
    logic [NP*PIX-1:0] peakIn;
    logic              outReady;
    logic              clrErr;
    logic              outValid;
    logic [NP-1:0]     outData;
    logic [IW-1:0]     outPixelIdx;
    logic              outLast;
    logic              overrunErr;
    logic [7:0]        dropCnt;
`ifdef PEAK_STREAM_FRAME_TAG_EN
    logic [7:0]        frameTag;
`endif

    always #5 clk = ~clk;

    peak_result_streamer #(.NP(NP), .PIXEL_NUM(PIX)) dut (
        .clk        (clk),
        .res        (res),
        .peakValid  (peakValid),
        .peakIn     (peakIn),
        .outReady   (outReady),
        .outValid   (outValid),
        .outData    (outData),
        .outPixelIdx(outPixelIdx),
        .outLast    (outLast),
        .overrunErr (overrunErr),
        .clrErr     (clrErr),
        .dropCnt    (dropCnt)
`ifdef PEAK_STREAM_FRAME_TAG_EN
        ,
        .frameTag   (frameTag)
`endif
    );

    typedef struct {
        logic [NP-1:0] data;
        int            idx;
        int            last;
        int            tag;
    } beat_t;

    beat_t exp_q[$];
    int    frame_rem[$];
    int    m_err  = 0;
    int    m_drop = 0;
    int    m_tag  = 0;
    int    checks   = 0;
    int    failures = 0;

    bit            have_prev = 0;
    bit            prev_valid, prev_ready;
    logic [NP-1:0] prev_data;
    logic [IW-1:0] prev_idx;
    logic          prev_last;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [NP*PIX-1:0] rand_frame();
        logic [NP*PIX-1:0] f;
        for (int p = 0; p < PIX; p++) begin
            f[p*NP +: NP] = NP'($urandom_range(0, 1023));
        end
        return f;
    endfunction

    task automatic model_flush();
        exp_q.delete();
        frame_rem.delete();
        m_err     = 0;
        m_drop    = 0;
        m_tag     = 0;
        have_prev = 0;
    endtask

    // Frame-level model. Outstanding frames are the active frame plus the pending one.
    task automatic model_step();
        int  held      = frame_rem.size();
        bit  finishing = (held > 0) && outReady && (frame_rem[0] == 1);
        bit  drop      = peakValid && (held == 2) && !finishing;
        beat_t b;
        if (held > 0 && outReady) begin
            frame_rem[0] = frame_rem[0] - 1;
            if (frame_rem[0] == 0) void'(frame_rem.pop_front());
        end
        if (drop) begin
            m_err  = 1;
            m_drop = clrErr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (clrErr) begin
            m_err  = 0;
            m_drop = 0;
        end
        if (peakValid && !drop) begin
            for (int p = 0; p < PIX; p++) begin
                b.data = peakIn[p*NP +: NP];
                b.idx  = p;
                b.last = (p == PIX - 1) ? 1 : 0;
                b.tag  = m_tag;
                exp_q.push_back(b);
            end
            frame_rem.push_back(PIX);
            m_tag = (m_tag + 1) % 256;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!res) model_step();
    end

    // Monitor: compares DUT outputs against the scoreboard on every falling edge.
    task automatic monitor_step();
        beat_t e;
        chk("outValid", 32'(outValid), 32'(exp_q.size() != 0));
        chk("overrunErr", 32'(overrunErr), 32'(m_err));
        chk("dropCnt", 32'(dropCnt), 32'(m_drop));
        if (have_prev && prev_valid && !prev_ready) begin
            chk("hold_stable", 32'({outData, outPixelIdx, outLast}),
                32'({prev_data, prev_idx, prev_last}));
        end
        if (outValid && outReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                $display("beat idx=%0d data=%0d last=%0b", outPixelIdx, outData, outLast);
                chk("outData", 32'(outData), 32'(e.data));
                chk("outPixelIdx", 32'(outPixelIdx), 32'(e.idx));
                chk("outLast", 32'(outLast), 32'(e.last));
`ifdef PEAK_STREAM_FRAME_TAG_EN
                chk("frameTag", 32'(frameTag), 32'(e.tag));
`endif
            end
        end
        have_prev  = 1;
        prev_valid = outValid;
        prev_ready = outReady;
        prev_data  = outData;
        prev_idx   = outPixelIdx;
        prev_last  = outLast;
    endtask

    initial forever begin
        @(negedge clk);
        if (!res) monitor_step();
    end

    // One clock of stimulus. peakIn carries garbage when not valid, which must be ignored.
    task automatic step(bit pv, logic [NP*PIX-1:0] d, bit rdy, bit clr);
        peakValid = pv;
        peakIn    = pv ? d : rand_frame();
        outReady  = rdy;
        clrErr    = clr;
        @(posedge clk);
        #1;
        peakValid = 1'b0;
        clrErr    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (frame_rem.size() != 0 && n < 100) begin
            step(0, '0, 1, 0);
            n++;
        end
        step(0, '0, 1, 0);
        chk("drain_timeout", 32'(frame_rem.size()), 32'(0));
    endtask

    initial begin
        res = 1'b1; peakValid = 1'b0; peakIn = '0; outReady = 1'b0; clrErr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outValid", 32'(outValid), 32'(0));
        chk("rst_outData", 32'(outData), 32'(0));
        chk("rst_outPixelIdx", 32'(outPixelIdx), 32'(0));
        chk("rst_outLast", 32'(outLast), 32'(0));
        chk("rst_overrunErr", 32'(overrunErr), 32'(0));
        chk("rst_dropCnt", 32'(dropCnt), 32'(0));
        res = 1'b0;

        // Single frame with ready held high. Pixel 0 carries 108.
        step(1, {10'd300, 10'd512, 10'd108}, 1, 0);
        chk("latency_valid", 32'(outValid), 32'(1));
        chk("first_pixel", 32'(outData), 32'(108));
        repeat (5) step(0, '0, 1, 0);

        // Ready toggles 1010 while frames arrive with spacing that avoids drops.
        for (int i = 0; i < 48; i++) begin
            step((i % 8) == 0, rand_frame(), (i % 2) == 0, 0);
        end
        drain();

        // With ready low, frame A goes active, B goes pending and C is dropped.
        step(1, rand_frame(), 0, 0);
        step(1, rand_frame(), 0, 0);
        step(1, rand_frame(), 0, 0);
        step(0, '0, 0, 0);
        chk("drop_err", 32'(overrunErr), 32'(1));
        chk("drop_cnt", 32'(dropCnt), 32'(1));
        drain();
        step(0, '0, 1, 1);
        chk("clr_err", 32'(overrunErr), 32'(0));
        chk("clr_cnt", 32'(dropCnt), 32'(0));

        // A frame arriving with the last beat goes back to back, with no bubble.
        for (int i = 0; i < 12; i++) step((i % 3) == 0, rand_frame(), 1, 0);
        drain();

        // When a clear coincides with a drop, the drop wins.
        step(1, rand_frame(), 0, 0);
        step(1, rand_frame(), 0, 0);
        step(1, rand_frame(), 0, 1);
        step(0, '0, 0, 0);
        chk("clr_vs_drop_cnt", 32'(dropCnt), 32'(1));
        drain();
        step(0, '0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 3, rand_frame(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0);
        end
        drain();

        // Reset mid-frame, when index 1 is presented.
        step(1, rand_frame(), 1, 0);
        step(0, '0, 1, 0);
        chk("pre_rst_idx", 32'(outPixelIdx), 32'(1));
        res = 1'b1;
        model_flush();
        #1;
        chk("midrst_outValid", 32'(outValid), 32'(0));
        chk("midrst_outData", 32'(outData), 32'(0));
        chk("midrst_outPixelIdx", 32'(outPixelIdx), 32'(0));
        chk("midrst_outLast", 32'(outLast), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
        repeat (6) step(0, '0, 1, 0);
        step(1, rand_frame(), 1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
